load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 1000: number of 32-bit words in the attached data memory.
REQ-002 clk  input  1: single clock; all state updates on posedge.
REQ-003 reset  input  1: asynchronous, active-low reset.
REQ-004 req_valid  input  1: core presents an access request.
REQ-005 req_ready  output  1: unit can accept a request.
REQ-006 req_write  input  1: 1 = store, 0 = load.
REQ-007 req_addr  input  32: byte address.
REQ-008 req_size  input  2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-009 req_unsigned  input  1: loads zero-extend when 1 and sign-extend when 0.
REQ-010 req_wdata  input  32: store data, right-aligned.
REQ-011 resp_valid  output  1: one-cycle completion pulse.
REQ-012 resp_rdata  output  32: extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1: access rejected; valid with resp_valid.
REQ-014 mem_address  output  32: word index, req_addr[31:2].
REQ-015 mem_write_data  output  32: merged word to write.
REQ-016 mem_read_data  input  32: combinational read data from memory.
REQ-017 MemRead  output  1: memory read enable.
REQ-018 MemWrite  output  1: memory write enable; memory commits on negedge clk.

Function
REQ-019 The SHALL use FSM states IDLE, READ, WRITE and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on the posedge where req_valid and req_ready are both 1, and the request fields are latched at that edge.
REQ-021 Load path: IDLE -> READ -> RESP -> IDLE, with resp_valid 2 cycles after acceptance.
REQ-022 Word store path: IDLE -> WRITE -> RESP -> IDLE.
REQ-023 Byte and half stores SHALL use read-modify-write: IDLE -> READ -> WRITE -> RESP -> IDLE.
REQ-024 In the merged store word, only the addressed byte or half SHALL be replaced; all other bytes keep the value read in READ.
REQ-025 MemRead SHALL be 1 only in READ and MemWrite SHALL be 1 only in WRITE.
REQ-026 All memory-side outputs SHALL be registered and stable from the posedge, so that the negedge commit sees settled values.
REQ-027 Outside READ and WRITE, mem_address and mem_write_data SHALL be 0.
REQ-028 In READ, mem_read_data SHALL be captured at the closing posedge.
REQ-029 Load data SHALL be byte or half selected by req_addr[1:0] (little-endian) and then extended per req_unsigned.
REQ-030 An error SHALL be raised when the word index is >= MEM_WORDS or when req_size = 11.
REQ-031 On an error the FSM SHALL go IDLE -> RESP with resp_error = 1, resp_rdata = 0, and no MemRead or MemWrite.
REQ-032 resp_valid SHALL be high for exactly one cycle, in RESP.
REQ-033 The unit accepts no backpressure; a new request can be accepted in the cycle after RESP.
REQ-034 A req_valid asserted while req_ready = 0 SHALL be ignored, and is not queued.

Reset
REQ-035 Asserting reset low SHALL immediately force IDLE.
REQ-036 Asserting reset low SHALL immediately force req_ready = 1.
REQ-037 Asserting reset low SHALL immediately force resp_valid = 0, resp_error = 0 and resp_rdata = 0.
REQ-038 Asserting reset low SHALL immediately force MemRead = 0, MemWrite = 0, mem_address = 0 and mem_write_data = 0, regardless of the current state.
REQ-039 A reset during WRITE SHALL drop MemWrite before the next negedge when reset precedes it; the in-flight access is discarded without a response.

Configuration
REQ-040 Macro MISALIGN_TRAP_EN defined: a half access with req_addr[0] = 1, or a word access with req_addr[1:0] != 0, SHALL produce an error response per REQ-031.
REQ-041 Macro MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be ignored (half uses req_addr[1]; word uses offset 0) and the access completes normally.

Verification
REQ-042 Memory initialised with word i = i; load word at addr 0x14 -> resp_rdata = 0x00000005 two cycles after accept, resp_error = 0.
REQ-043 Store word 0x80FF1234 at addr 0x20, then load signed byte at 0x21 -> 0x00000012; load signed half at 0x22 -> 0xFFFF80FF; load unsigned byte at 0x23 -> 0x00000080.
REQ-044 Store byte 0xAB at addr 0x31 over word 12 (value 0x0000000C) -> MemWrite with mem_write_data = 0x0000AB0C, mem_address = 12, and exactly one MemRead cycle beforehand.
REQ-045 Load at addr 0x00000FA0 (index 1000) -> resp_error = 1, resp_rdata = 0, MemRead never asserted.
REQ-046 Word load at addr 0x16 -> with MISALIGN_TRAP_EN, resp_error = 1; without it, resp_rdata = 0x00000005.
REQ-047 Assert reset low during the WRITE state of a word store -> MemWrite = 0 immediately, no resp_valid, memory word unchanged, req_ready = 1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a word-addressed memory, byte/half stores via RMW.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        MemRead,
   output logic        MemWrite
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

   state_e      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] index_q, index_d;
   logic [15:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;

   logic out_of_range, misalign, req_err;

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wd,
                                         input logic [1:0] off, input logic [1:0] size);
      logic [31:0] r;
      r = word;
      if (size == 2'b00) r[{off, 3'b000} +: 8] = wd[7:0];
      else               r[{off[1], 4'b0000} +: 16] = wd;
      return r;
   endfunction

   assign out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
`ifdef MISALIGN_TRAP_EN
   assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign req_err = out_of_range || (req_size == 2'b11) || misalign;

   // Memory/response outputs are computed for the state being entered, then registered.
   always_comb begin
      state_d          = state_q;
      write_d          = write_q;
      size_d           = size_q;
      unsigned_d       = unsigned_q;
      off_d            = off_q;
      index_d          = index_q;
      wdata_d          = wdata_q;
      resp_valid_d     = 1'b0;
      resp_error_d     = 1'b0;
      resp_rdata_d     = 32'h0;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      mem_address_d    = 32'h0;
      mem_write_data_d = 32'h0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               off_d      = req_addr[1:0];
               index_d    = req_addr[31:2];
               wdata_d    = req_wdata[15:0];
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end else if (req_write && (req_size == 2'b10)) begin
                  state_d          = WRITE;
                  mem_write_d      = 1'b1;
                  mem_address_d    = {2'b00, req_addr[31:2]};
                  mem_write_data_d = req_wdata;
               end else begin
                  state_d       = READ;
                  mem_read_d    = 1'b1;
                  mem_address_d = {2'b00, req_addr[31:2]};
               end
            end
         end
         READ: begin
            if (write_q) begin
               state_d          = WRITE;
               mem_write_d      = 1'b1;
               mem_address_d    = {2'b00, index_q};
               mem_write_data_d = merge(mem_read_data, wdata_q, off_q, size_q);
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = extract(mem_read_data, off_q, size_q, unsigned_q);
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         write_q          <= 1'b0;
         size_q           <= 2'b00;
         unsigned_q       <= 1'b0;
         off_q            <= 2'b00;
         index_q          <= 30'h0;
         wdata_q          <= 16'h0;
         resp_valid_q     <= 1'b0;
         resp_error_q     <= 1'b0;
         resp_rdata_q     <= 32'h0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_address_q    <= 32'h0;
         mem_write_data_q <= 32'h0;
      end else begin
         state_q          <= state_d;
         write_q          <= write_d;
         size_q           <= size_d;
         unsigned_q       <= unsigned_d;
         off_q            <= off_d;
         index_q          <= index_d;
         wdata_q          <= wdata_d;
         resp_valid_q     <= resp_valid_d;
         resp_error_q     <= resp_error_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign resp_valid     = resp_valid_q;
   assign resp_error     = resp_error_q;
   assign resp_rdata     = resp_rdata_q;
   assign MemRead        = mem_read_q;
   assign MemWrite       = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-in-WRITE sequence,
// and randomized requests against a request-level memory model.
module tb_load_store_unit;
   localparam int unsigned MW = 1000;

   logic        clk, reset;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
   logic        MemRead, MemWrite;

   logic [31:0] mem     [MW];
   logic [31:0] ref_mem [MW];
   bit          mem_ready;
   int          n_pass, n_total;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs [18];

   load_store_unit #(.MEM_WORDS(MW)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_error     (resp_error),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory commits on negedge; read is combinational.
   always @(negedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < MW; i++) mem[i] = 32'(i);
         mem_ready = 1'b1;
      end else if (MemWrite && (mem_address < MW)) begin
         mem[mem_address[9:0]] = mem_write_data;
      end
   end

   assign mem_read_data = (mem_address < MW) ? mem[mem_address[9:0]] : 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Request-level model: computes response, cycle counts and updates ref_mem.
   task automatic ref_model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wd, output logic err,
                            output logic [31:0] rd, output int lat, output int nrd,
                            output int nwr);
      int unsigned idx, nbytes, sh;
      logic [31:0] mask, w;
      bit          mis;
      idx    = addr >> 2;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (addr % nbytes) != 0;
`endif
      err = (idx >= MW) || (size == 2'd3) || mis;
      rd  = 32'h0;
      lat = 1;
      nrd = 0;
      nwr = 0;
      if (!err) begin
         sh   = 8 * ((addr % 4) / nbytes * nbytes);
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
         if (wr) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
            nwr = 1;
            nrd = (nbytes == 4) ? 0 : 1;
            lat = nrd + 2;
         end else begin
            w = (ref_mem[idx] >> sh) & mask;
            if (!uns && nbytes < 4 && w[8 * nbytes - 1]) w = w | ~mask;
            rd  = w;
            nrd = 1;
            lat = 2;
         end
      end
   endtask

   task automatic run_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd, input bit use_exp,
                          input logic exp_err, input logic [31:0] exp_rd, input bit hold,
                          input string tag);
      logic        m_err;
      logic [31:0] m_rd, wa, wdat;
      int          m_lat, m_nrd, m_nwr, lat, nrd, nwr, rd_cyc, wr_cyc;
      int unsigned idx;
      bit          got;
      ref_model(wr, addr, size, uns, wd, m_err, m_rd, m_lat, m_nrd, m_nwr);
      if (use_exp) begin
         m_err = exp_err;
         m_rd  = exp_rd;
      end
      idx = addr >> 2;
      lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0; wa = 0; wdat = 0; got = 0;
      @(negedge clk);
      check({tag, ":idle_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
      @(posedge clk);
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge clk);
         if (hold) begin
            req_write = 1'b1; req_addr = 32'h0; req_size = 2'd2; req_wdata = 32'hDEAD_BEEF;
         end else begin
            req_valid = 1'b0;
         end
         if (MemRead) begin nrd++; rd_cyc = c; end
         if (MemWrite) begin nwr++; wr_cyc = c; wa = mem_address; wdat = mem_write_data; end
         if (!MemRead && !MemWrite) begin
            check({tag, ":quiet_addr"}, mem_address, 32'h0);
            check({tag, ":quiet_wdata"}, mem_write_data, 32'h0);
         end
         check({tag, ":busy_ready"}, 32'(req_ready), 32'd0);
         if (resp_valid) begin
            got = 1'b1;
            lat = c;
            check({tag, ":err"}, 32'(resp_error), 32'(m_err));
            check({tag, ":rdata"}, resp_rdata, m_rd);
         end
      end
      req_valid = 1'b0;
      if (!got) check({tag, ":timeout"}, 32'd0, 32'd1);
      check({tag, ":latency"}, 32'(lat), 32'(m_lat));
      check({tag, ":memread_cycles"}, 32'(nrd), 32'(m_nrd));
      check({tag, ":memwrite_cycles"}, 32'(nwr), 32'(m_nwr));
      if (m_nwr != 0 && idx < MW) begin
         check({tag, ":waddr"}, wa, 32'(idx));
         check({tag, ":wdata"}, wdat, ref_mem[idx]);
         check({tag, ":mem_word"}, mem[idx], ref_mem[idx]);
         if (m_nrd != 0) check({tag, ":rmw_order"}, 32'(wr_cyc), 32'(rd_cyc + 1));
      end
   endtask

   initial begin
      logic [31:0] a, d;
      logic [1:0]  s;
      int unsigned r, idx;
      bit          saw;
      n_pass = 0; n_total = 0;
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
      req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
      for (int i = 0; i < MW; i++) ref_mem[i] = 32'(i);

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_error", 32'(resp_error), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_memread", 32'(MemRead), 32'd0);
      check("rst_memwrite", 32'(MemWrite), 32'd0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_wdata", mem_write_data, 32'h0);
      reset = 1'b1;

      vecs[0]  = '{1'b0, 32'h14,  2'd2, 1'b0, 32'h0,         1'b0, 32'h0000_0005};
      vecs[1]  = '{1'b1, 32'h20,  2'd2, 1'b0, 32'h80FF_1234, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 32'h21,  2'd0, 1'b0, 32'h0,         1'b0, 32'h0000_0012};
      vecs[3]  = '{1'b0, 32'h22,  2'd1, 1'b0, 32'h0,         1'b0, 32'hFFFF_80FF};
      vecs[4]  = '{1'b0, 32'h23,  2'd0, 1'b1, 32'h0,         1'b0, 32'h0000_0080};
      vecs[5]  = '{1'b1, 32'h31,  2'd0, 1'b0, 32'h5555_55AB, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'hFA0, 2'd2, 1'b0, 32'h0,         1'b1, 32'h0};
`ifdef MISALIGN_TRAP_EN
      vecs[7]  = '{1'b0, 32'h16,  2'd2, 1'b0, 32'h0,         1'b1, 32'h0};
`else
      vecs[7]  = '{1'b0, 32'h16,  2'd2, 1'b0, 32'h0,         1'b0, 32'h0000_0005};
`endif
      vecs[8]  = '{1'b0, 32'h10,  2'd3, 1'b0, 32'h0,         1'b1, 32'h0};
      vecs[9]  = '{1'b0, 32'h23,  2'd0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FF80};
      vecs[10] = '{1'b0, 32'h22,  2'd1, 1'b1, 32'h0,         1'b0, 32'h0000_80FF};
      vecs[11] = '{1'b1, 32'h32,  2'd1, 1'b0, 32'h0000_BEEF, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 32'h30,  2'd2, 1'b0, 32'h0,         1'b0, 32'hBEEF_AB0C};
      vecs[13] = '{1'b1, 32'hF9C, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 32'hF9C, 2'd2, 1'b1, 32'h0,         1'b0, 32'h1234_5678};
      vecs[15] = '{1'b1, 32'hFA0, 2'd0, 1'b0, 32'h0000_00EE, 1'b1, 32'h0};
`ifdef MISALIGN_TRAP_EN
      vecs[16] = '{1'b1, 32'h21,  2'd1, 1'b0, 32'h0000_7777, 1'b1, 32'h0};
      vecs[17] = '{1'b0, 32'h20,  2'd2, 1'b0, 32'h0,         1'b0, 32'h80FF_1234};
`else
      vecs[16] = '{1'b1, 32'h21,  2'd1, 1'b0, 32'h0000_7777, 1'b0, 32'h0};
      vecs[17] = '{1'b0, 32'h20,  2'd2, 1'b0, 32'h0,         1'b0, 32'h80FF_7777};
`endif
      for (int i = 0; i < 18; i++) begin
         run_req(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wd, 1'b1,
                 vecs[i].err, vecs[i].rd, (i % 4) == 1, $sformatf("vec%0d", i));
      end
      check("vec5_word12", mem[12], 32'hBEEF_AB0C);
      check("held_valid_ignored", mem[0], ref_mem[0]);

      // Reset asserted inside WRITE of a word store, before its negedge commit.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_size = 2'd2;
      req_unsigned = 1'b0; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rstw_pre_memwrite", 32'(MemWrite), 32'd1);
      reset = 1'b0;
      #1;
      check("rstw_memwrite", 32'(MemWrite), 32'd0);
      check("rstw_memread", 32'(MemRead), 32'd0);
      check("rstw_ready", 32'(req_ready), 32'd1);
      check("rstw_addr", mem_address, 32'h0);
      check("rstw_wdata", mem_write_data, 32'h0);
      check("rstw_resp_valid", 32'(resp_valid), 32'd0);
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) saw = 1'b1;
      end
      reset = 1'b1;
      check("rstw_no_resp", 32'(saw), 32'd0);
      check("rstw_mem_unchanged", mem[16], ref_mem[16]);
      run_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "rstw_reload");

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 15);
         s = (r == 15) ? 2'd3 : 2'(r % 3);
         idx = ($urandom_range(0, 9) == 0) ? $urandom_range(995, 1030) : $urandom_range(0, 31);
         a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         run_req(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), d, 1'b0, 1'b0,
                 32'h0, ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
      end
      check("final_word0", mem[0], ref_mem[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
